// File: rtl/jam_pkg.sv
// Shared types and sizing for the JAM cost-matrix source.
// Sizes default to an 8x8 matrix of 7-bit costs with a 10-bit lower-bound sum.
package jam_pkg;

  localparam int COST_W  = 7;
  localparam int IDX_W   = 3;
  localparam int SUM_W   = 10;
  localparam int N_ENTRY = 64;

  localparam logic [COST_W-1:0] MAX_COST = 7'd127;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/jam_cost_mem.sv
// Cost register file: one synchronous write port, one registered read port (1 cycle).
// No backpressure; a deasserted rd_en forces the registered output to zero.
module jam_cost_mem
  import jam_pkg::*;
#(
  parameter int DW    = COST_W,
  parameter int AW    = 6,
  parameter int DEPTH = N_ENTRY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rd_dat_q;
  logic [DW-1:0] rd_dat_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_vld) begin
      mem_d[wr_addr] = wr_dat;
    end
    rd_dat_d = rd_en ? mem_q[rd_addr] : '0;
  end

  // Storage contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/jam_cost_table.sv
// Loads an 8x8 cost matrix over a valid/ready stream, tracking row minima and their sum,
// then serves 1-cycle registered W/J lookups; LD_READY drops in READY and while CLEAR is high.
module jam_cost_table #(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int IDX_W  = jam_pkg::IDX_W,
  parameter int SUM_W  = jam_pkg::SUM_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [COST_W-1:0] LD_DATA,
  input  logic              CLEAR,
  output logic              TABLE_READY,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic [IDX_W-1:0]  ROW_SEL,
  output logic [COST_W-1:0] ROW_MIN,
  output logic [SUM_W-1:0]  LB
);

  import jam_pkg::*;

  localparam int ADDR_W = 2 * IDX_W;
  localparam int N_ROW  = 1 << IDX_W;
  localparam logic [COST_W-1:0] COST_INIT = COST_W'(MAX_COST);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [COST_W-1:0]   run_min_q, run_min_d;
  logic [COST_W-1:0]   row_min_q [N_ROW];
  logic [COST_W-1:0]   row_min_d [N_ROW];
  logic [SUM_W-1:0]    lb_q, lb_d;
  logic [COST_W-1:0]   row_fin;
  logic                accept;
  logic                rd_en;

  assign LD_READY = (state_q == LOAD) && !CLEAR;
  assign accept   = LD_VALID && LD_READY;
  assign rd_en    = (state_q == READY) && !CLEAR;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    row_min_d = row_min_q;
    lb_d      = lb_q;
    // Minimum including the current beat; only meaningful past a row's first column.
    row_fin   = (LD_DATA < run_min_q) ? LD_DATA : run_min_q;
    if (CLEAR) begin
      state_d   = LOAD;
      cnt_d     = '0;
      run_min_d = COST_INIT;
      lb_d      = '0;
      for (int r = 0; r < N_ROW; r++) begin
        row_min_d[r] = COST_INIT;
      end
    end else if (accept) begin
      cnt_d     = cnt_q + ADDR_W'(1);
      run_min_d = (cnt_q[IDX_W-1:0] == '0) ? LD_DATA : row_fin;
      if (cnt_q[IDX_W-1:0] == '1) begin
        row_min_d[cnt_q[ADDR_W-1:IDX_W]] = row_fin;
        lb_d = lb_q + SUM_W'(row_fin);
      end
      if (cnt_q == '1) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      run_min_q <= COST_INIT;
      lb_q      <= '0;
      for (int r = 0; r < N_ROW; r++) begin
        row_min_q[r] <= COST_INIT;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      lb_q      <= lb_d;
      row_min_q <= row_min_d;
    end
  end

  jam_cost_mem #(
    .DW    (COST_W),
    .AW    (ADDR_W),
    .DEPTH (1 << ADDR_W)
  ) u_mem (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_vld  (accept),
    .wr_addr (cnt_q),
    .wr_dat  (LD_DATA),
    .rd_en   (rd_en),
    .rd_addr ({W, J}),
    .rd_dat  (Cost)
  );

  assign TABLE_READY = (state_q == READY);
  assign ROW_MIN     = row_min_q[ROW_SEL];
  assign LB          = lb_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Randomized bench for jam_cost_table against a matrix/row-minimum reference model.
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       LD_VALID = 1'b0;
  logic       LD_READY;
  logic [6:0] LD_DATA = '0;
  logic       CLEAR = 1'b0;
  logic       TABLE_READY;
  logic [2:0] W = '0;
  logic [2:0] J = '0;
  logic [6:0] Cost;
  logic [2:0] ROW_SEL = '0;
  logic [6:0] ROW_MIN;
  logic [9:0] LB;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_mem [64];

  jam_cost_table dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .LD_VALID    (LD_VALID),
    .LD_READY    (LD_READY),
    .LD_DATA     (LD_DATA),
    .CLEAR       (CLEAR),
    .TABLE_READY (TABLE_READY),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .ROW_SEL     (ROW_SEL),
    .ROW_MIN     (ROW_MIN),
    .LB          (LB)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Row r reads 127 until all 8 of its beats have been accepted.
  function automatic int exp_rowmin(input int r, input int done);
    int m;
    m = 127;
    if (8 * (r + 1) > done) return 127;
    for (int c = 0; c < 8; c++) begin
      if (exp_mem[8*r + c] < m) m = exp_mem[8*r + c];
    end
    return m;
  endfunction

  function automatic int exp_lb(input int done);
    int s;
    s = 0;
    for (int r = 0; r < 8; r++) begin
      if (8 * (r + 1) <= done) s += exp_rowmin(r, done);
    end
    return s;
  endfunction

  task automatic do_load(input int gap_max, input int n_beats, output int ncyc);
    int k, gap;
    bit acc;
    k = 0; gap = 0; ncyc = 0;
    while (k < n_beats && ncyc < 4000) begin
      @(negedge CLK);
      chk_eq("tready_in_load", 32'(TABLE_READY), 0);
      chk_eq("lb_in_load", 32'(LB), exp_lb(k));
      ROW_SEL = 3'($urandom_range(0, 7));
      LD_VALID = (gap == 0);
      if (gap > 0) gap--;
      LD_DATA = LD_VALID ? 7'(exp_mem[k]) : 7'($urandom_range(0, 127));
      #1;
      chk_eq("ld_ready_in_load", 32'(LD_READY), 1);
      chk_eq("rowmin_in_load", 32'(ROW_MIN), exp_rowmin(int'(ROW_SEL), k));
      acc = LD_VALID && LD_READY;
      @(posedge CLK);
      ncyc++;
      if (acc) begin
        k++;
        if (gap_max > 0) gap = $urandom_range(0, gap_max);
      end
    end
    if (k < n_beats) chk_eq("load_timeout", k, n_beats);
  endtask

  task automatic finish_load();
    @(negedge CLK);
    LD_VALID = 1'b0;
    chk_eq("tready_after_last", 32'(TABLE_READY), 1);
    chk_eq("lb_final", 32'(LB), exp_lb(64));
    chk_eq("ld_ready_in_ready", 32'(LD_READY), 0);
    for (int r = 0; r < 8; r++) begin
      @(negedge CLK);
      ROW_SEL = 3'(r);
      #1;
      chk_eq("rowmin_final", 32'(ROW_MIN), exp_rowmin(r, 64));
    end
  endtask

  // Pipelined lookups; LD_VALID toggles randomly to show it is ignored in READY.
  task automatic do_lookups(input int n, input bit seq);
    int a, pa;
    pa = 0;
    for (int i = 0; i <= n; i++) begin
      @(negedge CLK);
      if (i > 0) chk_eq("cost_lookup", 32'(Cost), exp_mem[pa]);
      if (i < n) begin
        a = seq ? i : $urandom_range(0, 63);
        W = a[5:3];
        J = a[2:0];
        pa = a;
        LD_VALID = 1'($urandom_range(0, 1));
        LD_DATA = 7'($urandom_range(0, 127));
      end
    end
    LD_VALID = 1'b0;
  endtask

  task automatic do_clear(input bit coinc);
    @(negedge CLK);
    CLEAR = 1'b1;
    LD_VALID = coinc;
    LD_DATA = 7'($urandom_range(0, 127));
    #1;
    chk_eq("ld_ready_during_clear", 32'(LD_READY), 0);
    @(negedge CLK);
    CLEAR = 1'b0;
    LD_VALID = 1'b0;
    ROW_SEL = 3'($urandom_range(0, 7));
    #1;
    chk_eq("tready_after_clear", 32'(TABLE_READY), 0);
    chk_eq("lb_after_clear", 32'(LB), 0);
    chk_eq("cost_after_clear", 32'(Cost), 0);
    chk_eq("rowmin_after_clear", 32'(ROW_MIN), 127);
    chk_eq("ld_ready_after_clear", 32'(LD_READY), 1);
  endtask

  initial begin
    int ncyc;
    #1 RST_N = 1'b0;
    #11;
    chk_eq("rst_tready", 32'(TABLE_READY), 0);
    chk_eq("rst_cost", 32'(Cost), 0);
    chk_eq("rst_lb", 32'(LB), 0);
    chk_eq("rst_ld_ready", 32'(LD_READY), 1);
    chk_eq("rst_rowmin", 32'(ROW_MIN), 127);
    @(negedge CLK);
    RST_N = 1'b1;

    // Ascending matrix, no gaps.
    for (int k = 0; k < 64; k++) exp_mem[k] = k;
    do_load(0, 64, ncyc);
    chk_eq("load_cycles_nogap", ncyc, 64);
    finish_load();
    chk_eq("lb_ascending", 32'(LB), 224);
    @(negedge CLK);
    ROW_SEL = 3'd5;
    W = 3'd3; J = 3'd5;
    @(negedge CLK);
    chk_eq("rowmin_row5", 32'(ROW_MIN), 40);
    chk_eq("cost_w3_j5", 32'(Cost), 29);
    W = 3'd7; J = 3'd7;
    @(negedge CLK);
    chk_eq("cost_w7_j7", 32'(Cost), 63);
    do_lookups(40, 1'b0);

    // Same matrix with random gaps.
    do_clear(1'b0);
    do_load(3, 64, ncyc);
    finish_load();
    chk_eq("lb_gapped", 32'(LB), 224);
    do_lookups(64, 1'b1);

    // Saturated matrix.
    do_clear(1'b0);
    for (int k = 0; k < 64; k++) exp_mem[k] = 127;
    do_load(1, 64, ncyc);
    finish_load();
    chk_eq("lb_saturated", 32'(LB), 1016);
    do_lookups(64, 1'b1);

    // Random matrix.
    do_clear(1'b0);
    for (int k = 0; k < 64; k++) exp_mem[k] = $urandom_range(0, 127);
    do_load(2, 64, ncyc);
    finish_load();
    do_lookups(50, 1'b0);

    // CLEAR at beat 20 with a coincident valid beat, then descending reload.
    do_clear(1'b0);
    for (int k = 0; k < 64; k++) exp_mem[k] = k;
    do_load(0, 20, ncyc);
    do_clear(1'b1);
    for (int k = 0; k < 64; k++) exp_mem[k] = 63 - k;
    do_load(2, 64, ncyc);
    finish_load();
    chk_eq("lb_descending", 32'(LB), 224);
    do_lookups(20, 1'b0);

    // Asynchronous reset while serving.
    @(negedge CLK);
    W = 3'd0; J = 3'd0;
    @(negedge CLK);
    chk_eq("cost_before_reset", 32'(Cost), 63);
    #2 RST_N = 1'b0;
    #1;
    chk_eq("async_rst_tready", 32'(TABLE_READY), 0);
    chk_eq("async_rst_cost", 32'(Cost), 0);
    chk_eq("async_rst_lb", 32'(LB), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    ROW_SEL = 3'd7;
    #1;
    chk_eq("ld_ready_after_reset", 32'(LD_READY), 1);
    chk_eq("rowmin_after_reset", 32'(ROW_MIN), 127);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Cost-matrix source sitting directly upstream of the job-assignment (JAM) search engine.
- Accepts an 8x8 worker/job cost matrix as a 64-beat valid/ready stream.
- Then serves W/J lookups with the 1-cycle registered Cost timing the search engine expects.
- While loading, also computes each worker's row minimum and their sum, a lower bound on any assignment cost that the search engine can use for pruning.

Parameters:
- COST_W, 7, bit width of one cost entry.
- IDX_W, 3, bit width of W/J; matrix is 2^IDX_W square. Only the defaults are verified.
- SUM_W, 10, width of the lower-bound sum; must hold 8*127=1016.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- LD_VALID  input  1  load beat valid.
- LD_READY  output  1  table accepts a load beat this cycle.
- LD_DATA  input  COST_W  cost entry, row-major order: beat k is worker k/8, job k%8.
- CLEAR  input  1  single-cycle request to discard the table and reload.
- TABLE_READY  output  1  matrix complete; lookups valid.
- W  input  IDX_W  worker index of lookup.
- J  input  IDX_W  job index of lookup.
- Cost  output  COST_W  registered lookup result.
- ROW_SEL  input  IDX_W  row-minimum read select.
- ROW_MIN  output  COST_W  combinational minimum of row ROW_SEL.
- LB  output  SUM_W  sum of the 8 row minima.

Behaviour:
- States: LOAD, READY.
- Reset: state=LOAD, load counter=0, TABLE_READY=0, Cost=0, LB=0, all row minima=127, matrix contents don't-care. RST_N is asynchronous; reset mid-load or mid-serve returns to these values immediately.

LOAD state:
- LD_READY = (state==LOAD) && !CLEAR; combinational.
- Accept = LD_VALID && LD_READY. On accept, write mem[cnt] <= LD_DATA and cnt <= cnt+1 (6-bit counter).
- Running row minimum: on the beat with cnt[2:0]==0, run_min <= LD_DATA; otherwise run_min <= min(run_min, LD_DATA).
- On the beat with cnt[2:0]==7:
  - row_min[cnt[5:3]] <= min(run_min, LD_DATA).
  - LB <= LB + that same value (zero-extended to SUM_W).
- On the 64th accept (cnt==63), move to READY next cycle. TABLE_READY goes 1 in the cycle after the last accepted beat. cnt wraps to 0.
- LD_VALID gaps of any length are legal; no state advances without an accept.

READY state:
- LD_READY=0; LD_VALID is ignored.
- Cost <= mem[{W,J}] every cycle. Cost for an address presented in cycle t appears in cycle t+1.
- In LOAD, Cost <= 0.

CLEAR:
- In any state: next cycle state=LOAD, cnt=0, LB=0, row minima=127, TABLE_READY=0, Cost=0.
- CLEAR coincident with LD_VALID: the beat is not accepted, because LD_READY is 0 that cycle.
- CLEAR in LOAD restarts the load from beat 0.

ROW_MIN:
- Reads row_min[ROW_SEL] at any time.
- Rows not yet completed read 127.

Arithmetic:
- Minima are unsigned compares.
- LB cannot overflow at SUM_W=10.

Decomposition:
- Package jam_pkg holds:
  - state enum {LOAD, READY}.
  - COST_W, IDX_W, SUM_W constants.
  - N_ENTRY = 64.
  - MAX_COST = 127.
- Sub-module jam_cost_mem: 64 x COST_W register file with one synchronous write port and one registered read port, with read-enable/zero-force input used in LOAD.
- Row-min/LB logic and the FSM stay in the top.

Test Plan:
- Load mem[k]=k (k=0..63), LD_VALID held high:
  - LD_READY stays high for 64 cycles.
  - TABLE_READY=1 one cycle after the last beat.
  - LB=224; ROW_MIN for ROW_SEL=5 is 40.
- After that load, drive W=3,J=5 in cycle t, then W=7,J=7 in cycle t+1 -> Cost=29 at t+1, Cost=63 at t+2.
- Same load with LD_VALID toggling 1/0 and random 0-3 cycle gaps -> identical final contents, LB=224, TABLE_READY only after exactly 64 accepts.
- All entries 127 -> LB=1016; all row minima 127; Cost=127 for every W/J.
- Assert CLEAR at beat 20 of a load, with LD_VALID high that same cycle:
  - that beat is not accepted; LB=0 next cycle.
  - then reload mem[k]=63-k -> LB=8*(7+6+...+0)=224 computed correctly.
- Deassert RST_N asynchronously while in READY:
  - TABLE_READY, Cost, LB go 0 immediately.
  - LD_READY is 1 after release.
